fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: XLEN, default 32, width of PC and instruction.
REQ-002 Parameter: IMEM_AW, default 30, word-address width toward the instruction cache.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc  input  XLEN  current fetch address from the PC register.
REQ-006 pc_en  output  1  PC advance/load enable, wired to the PC register's hazard_stall port (1 = PC loads pc_in).
REQ-007 flush  input  1  branch/jump redirect; buffered instructions are invalid.
REQ-008 ICACHE_ren  output  1  instruction read request.
REQ-009 ICACHE_addr  output  IMEM_AW  word address of the request.
REQ-010 ICACHE_stall  input  1  cache busy; ICACHE_rdata is valid in any cycle with ren=1 and stall=0.
REQ-011 ICACHE_rdata  input  XLEN  returned instruction word, used without byte reordering.
REQ-012 inst, inst_pc  output  XLEN each  head instruction and its PC toward IF/ID.
REQ-013 inst_valid  output  1  head entry present; id_ready  input  1  decode accepts head.

Function
REQ-014 States: FETCH, DISCARD; reset state FETCH.
REQ-015 FETCH: ICACHE_ren = ~buf_full; ICACHE_addr = pc[31:2]; pc[1:0] ignored.
REQ-016 FETCH return (ren=1, stall=0, flush=0): push {rdata, pc} into buffer at the edge; pc_en=1 that cycle.
REQ-017 FETCH with stall=1: ren and addr held; pc_en=0; buffer unchanged except pops.
REQ-018 Pop occurs when inst_valid & id_ready; push and pop in the same cycle are both honoured, count unchanged.
REQ-019 Buffer full: ren=0, pc_en=0 (no combinational path from id_ready to ren).
REQ-020 flush (either state): buffer emptied at the edge; pop ignored; pc_en=1 so the PC loads the redirect target.
REQ-021 flush in FETCH with ren=1, stall=0: returned word dropped; stay FETCH.
REQ-022 flush in FETCH with ren=1, stall=1: latch current word address; next state DISCARD.
REQ-023 DISCARD: ren=1, ICACHE_addr = latched address (request not withdrawn); pc_en=0 except on a further flush.
REQ-024 DISCARD with stall=0: returned word dropped; next state FETCH; first new request the following cycle.
REQ-025 inst/inst_pc held stable while inst_valid=1 and id_ready=0.
REQ-026 inst and inst_pc read 0 when inst_valid=0.

Reset
REQ-027 While rst_n=0: ICACHE_ren=0, pc_en=0, inst_valid=0, inst=0, inst_pc=0, buffer empty, state FETCH.
REQ-028 Reset asserted mid-request (stall=1) abandons the request; no DISCARD after release.
REQ-029 First ICACHE_ren=1 occurs in the first cycle with rst_n=1.

Configuration
REQ-030 Macro FETCH_BUF2_EN defined: buffer depth 2, full at count 2; fetch continues while decode stalls one cycle.
REQ-031 Macro undefined: depth 1, full at count 1; REQ-018 same-cycle push/pop still permitted only when not full, i.e. never with a held entry.

Structure
REQ-032 Package fetch_pkg: state enum {FETCH, DISCARD}, IMEM_AW default, FETCH_DEPTH constant derived from FETCH_BUF2_EN.
REQ-033 Sub-module fetch_buf: depth-1/2 FIFO of {inst, inst_pc} with push, pop, clear, full, empty; FSM stays in fetch_unit.

Verification
REQ-034 Reset release, pc=0x0000_0000, stall=0, rdata=0x0000_0013, id_ready=1 -> cycle 1 ren=1, addr=0, pc_en=1; cycle 2 inst_valid=1, inst=0x13, inst_pc=0.
REQ-035 stall=1 for 3 cycles at pc=0x40 -> addr=0x10 and ren=1 all 4 cycles, pc_en=1 only in the 4th.
REQ-036 id_ready=0, FETCH_BUF2_EN defined, stall=0 -> two pushes, then ren=0, pc_en=0; id_ready=1 one cycle -> ren=1 next cycle.
REQ-037 flush while stall=1 at pc=0x80 -> DISCARD, addr stays 0x20 with pc changed to 0x200; on stall=0 word dropped, next cycle addr=0x80.
REQ-038 flush with 2 valid entries and id_ready=1 -> inst_valid=0 next cycle, no entry popped to decode.
REQ-039 rst_n=0 asynchronously mid-stall -> ren, pc_en, inst_valid 0 immediately; after release fetch restarts from pc in FETCH.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_BUF2_EN selects a two-entry fetch buffer instead of one.
package fetch_pkg;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } state_e;

  localparam int unsigned IMEM_AW_DEF = 30;

`ifdef FETCH_BUF2_EN
  localparam int unsigned FETCH_DEPTH = 2;
`else
  localparam int unsigned FETCH_DEPTH = 1;
`endif

endpackage

// File: rtl/fetch_if.sv
// Instruction-cache request/response and IF/ID handoff bundle.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMEM_AW = IMEM_AW_DEF
);
  logic               ICACHE_ren;
  logic [IMEM_AW-1:0] ICACHE_addr;
  logic               ICACHE_stall;
  logic [XLEN-1:0]    ICACHE_rdata;
  logic [XLEN-1:0]    inst;
  logic [XLEN-1:0]    inst_pc;
  logic               inst_valid;
  logic               id_ready;

  modport master (
    output ICACHE_ren, ICACHE_addr, inst, inst_pc, inst_valid,
    input  ICACHE_stall, ICACHE_rdata, id_ready
  );

  modport slave (
    input  ICACHE_ren, ICACHE_addr, inst, inst_pc, inst_valid,
    output ICACHE_stall, ICACHE_rdata, id_ready
  );
endinterface

// File: rtl/fetch_buf.sv
// One- or two-entry FIFO holding {inst, inst_pc} between the cache and decode.
module fetch_buf #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_ent0;
  logic [W-1:0] r_ent1;
  logic [1:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      if (i_push && !i_pop)
        r_count <= r_count + 2'd1;
      else if (i_pop && !i_push)
        r_count <= r_count - 2'd1;

      // Entry 0 is always the head; entry 1 shifts down on a pop.
      if (i_pop) begin
        if (r_count == 2'd2)
          r_ent0 <= r_ent1;
        else if (i_push)
          r_ent0 <= i_data;
      end else if (i_push && r_count == 2'd0) begin
        r_ent0 <= i_data;
      end

      if (DEPTH > 1 && i_push &&
          ((r_count == 2'd1 && !i_pop) || (r_count == 2'd2 && i_pop)))
        r_ent1 <= i_data;
    end
  end

  assign o_data  = r_ent0;
  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'(DEPTH));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues I-cache reads, buffers returns for decode, and
// discards an in-flight request after a redirect. Buffer depth set by FETCH_BUF2_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMEM_AW = IMEM_AW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  input  logic            flush,
  fetch_if.master         bus
);
  state_e               r_state;
  state_e               w_state_nxt;
  logic [IMEM_AW-1:0]   r_disc_addr;
  logic [IMEM_AW-1:0]   w_fetch_addr;
  logic                 w_ren;
  logic                 w_pc_en;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_latch;
  logic                 w_full;
  logic                 w_empty;
  logic [2*XLEN-1:0]    w_head;
  logic                 w_unused_pc;

  assign w_fetch_addr = pc[IMEM_AW+1:2];
  assign w_unused_pc  = ^pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_disc_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch)
        r_disc_addr <= w_fetch_addr;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ren           = 1'b0;
    w_pc_en         = 1'b0;
    w_push          = 1'b0;
    w_latch         = 1'b0;
    bus.ICACHE_addr = w_fetch_addr;
    case (r_state)
      FETCH: begin
        w_ren = ~w_full;
        if (w_ren && !bus.ICACHE_stall) begin
          w_pc_en = 1'b1;
          w_push  = ~flush;
        end else if (w_ren && flush) begin
          w_latch     = 1'b1;
          w_state_nxt = DISCARD;
        end
        if (flush)
          w_pc_en = 1'b1;
      end
      DISCARD: begin
        // The stalled request must complete before a new address is issued.
        w_ren           = 1'b1;
        bus.ICACHE_addr = r_disc_addr;
        w_pc_en         = flush;
        if (!bus.ICACHE_stall)
          w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
    if (!rst_n) begin
      w_ren   = 1'b0;
      w_pc_en = 1'b0;
    end
  end

  assign w_pop = ~w_empty & bus.id_ready & ~flush;

  fetch_buf #(
    .W     (2 * XLEN),
    .DEPTH (FETCH_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_data  ({bus.ICACHE_rdata, pc}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.ICACHE_ren = w_ren;
  assign pc_en          = w_pc_en;
  assign bus.inst_valid = ~w_empty;
  assign bus.inst       = w_empty ? '0 : w_head[2*XLEN-1:XLEN];
  assign bus.inst_pc    = w_empty ? '0 : w_head[XLEN-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a scoreboard of buffered instructions.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        stall;
    logic        idr;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [1:0]  e_ren;   // 2 = 1 only with a two-entry buffer
    logic [1:0]  e_pcen;
    logic [29:0] e_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl[$];
  logic [63:0] sb[$];

  fetch_if #(.XLEN(32), .IMEM_AW(30)) bus ();

  fetch_unit #(.XLEN(32), .IMEM_AW(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pc    (pc),
    .pc_en (pc_en),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  function automatic logic res(input logic [1:0] v);
    return (v == 2'd2) ? (FETCH_DEPTH == 2) : v[0];
  endfunction

  task automatic add(input logic r, input logic f, input logic s, input logic i,
                     input logic [31:0] p, input logic [31:0] d,
                     input logic [1:0] er, input logic [1:0] ep, input logic [29:0] ea);
    vec_t v;
    v.rst = r; v.flush = f; v.stall = s; v.idr = i; v.pc = p; v.rdata = d;
    v.e_ren = er; v.e_pcen = ep; v.e_addr = ea;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        v;
    logic [63:0] head;
    logic        e_valid;

    //   rst f  s  idr pc            rdata          ren   pcen  addr
    add(0, 0, 0, 1, 32'h0,   32'h13,       2'd0, 2'd0, 30'h0);
    add(1, 0, 0, 1, 32'h0,   32'h13,       2'd1, 2'd1, 30'h0);
    add(1, 0, 1, 1, 32'h4,   32'h0,        2'd2, 2'd0, 30'h1);
    add(1, 0, 0, 1, 32'h4,   32'h00500093, 2'd1, 2'd1, 30'h1);
    add(1, 0, 1, 1, 32'h40,  32'h0,        2'd2, 2'd0, 30'h10);
    add(1, 0, 1, 1, 32'h40,  32'h0,        2'd1, 2'd0, 30'h10);
    add(1, 0, 1, 1, 32'h40,  32'h0,        2'd1, 2'd0, 30'h10);
    add(1, 0, 1, 1, 32'h40,  32'h0,        2'd1, 2'd0, 30'h10);
    add(1, 0, 0, 1, 32'h40,  32'hAAAA5555, 2'd1, 2'd1, 30'h10);
    add(1, 0, 1, 1, 32'h80,  32'h0,        2'd2, 2'd0, 30'h20);
    add(1, 0, 1, 1, 32'h80,  32'h0,        2'd1, 2'd0, 30'h20);
    add(1, 1, 1, 1, 32'h80,  32'h0,        2'd1, 2'd1, 30'h20);
    add(1, 0, 1, 1, 32'h200, 32'h0,        2'd1, 2'd0, 30'h20);
    add(1, 0, 0, 1, 32'h200, 32'hDEAD,     2'd1, 2'd0, 30'h20);
    add(1, 0, 0, 1, 32'h200, 32'h11,       2'd1, 2'd1, 30'h80);
    add(1, 0, 1, 1, 32'h204, 32'h0,        2'd2, 2'd0, 30'h81);
    add(1, 1, 0, 1, 32'h204, 32'h99,       2'd1, 2'd1, 30'h81);
    add(1, 0, 0, 1, 32'h300, 32'h22,       2'd1, 2'd1, 30'hC0);
    add(1, 0, 1, 0, 32'h304, 32'h0,        2'd2, 2'd0, 30'hC1);
    add(1, 0, 1, 0, 32'h304, 32'h0,        2'd2, 2'd0, 30'hC1);
    add(1, 0, 1, 1, 32'h304, 32'h0,        2'd2, 2'd0, 30'hC1);
    add(1, 0, 0, 0, 32'h400, 32'h100,      2'd1, 2'd1, 30'h100);
    add(1, 0, 0, 0, 32'h404, 32'h104,      2'd2, 2'd2, 30'h101);
    add(1, 0, 0, 0, 32'h408, 32'h108,      2'd0, 2'd0, 30'h102);
    add(1, 0, 0, 1, 32'h408, 32'h108,      2'd0, 2'd0, 30'h102);
    add(1, 0, 0, 0, 32'h408, 32'h108,      2'd1, 2'd1, 30'h102);
    add(1, 1, 0, 1, 32'h40C, 32'h0,        2'd0, 2'd1, 30'h103);
    add(1, 0, 0, 1, 32'h800, 32'h55,       2'd1, 2'd1, 30'h200);
    add(1, 0, 1, 1, 32'h804, 32'h0,        2'd2, 2'd0, 30'h201);

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rst_n            = v.rst;
      flush            = v.flush;
      pc               = v.pc;
      bus.ICACHE_stall = v.stall;
      bus.ICACHE_rdata = v.rdata;
      bus.id_ready     = v.idr;
      @(negedge clk);
      chk("ren",   int'(i), 32'(bus.ICACHE_ren),  32'(res(v.e_ren)));
      chk("pc_en", int'(i), 32'(pc_en),           32'(res(v.e_pcen)));
      chk("addr",  int'(i), 32'(bus.ICACHE_addr), 32'(v.e_addr));
      e_valid = v.rst && (sb.size() != 0);
      chk("inst_valid", int'(i), 32'(bus.inst_valid), 32'(e_valid));
      head = e_valid ? sb[0] : 64'h0;
      chk("inst",    int'(i), bus.inst,    head[63:32]);
      chk("inst_pc", int'(i), bus.inst_pc, head[31:0]);
      if (!v.rst || v.flush)
        sb.delete();
      else if (e_valid && v.idr)
        void'(sb.pop_front());
      if (v.rst && !v.flush && res(v.e_pcen))
        sb.push_back({v.rdata, v.pc});
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a stalled request with an entry held.
    flush = 1'b0; pc = 32'h900; bus.ICACHE_stall = 1'b0;
    bus.ICACHE_rdata = 32'h77; bus.id_ready = 1'b0;
    @(posedge clk);
    #1;
    pc = 32'h904; bus.ICACHE_stall = 1'b1;
    #1;
    chk("pre_rst_valid", 100, 32'(bus.inst_valid), 32'd1);
    chk("pre_rst_inst",  100, bus.inst, 32'h77);
    rst_n = 1'b0;
    #1;
    chk("rst_ren",     101, 32'(bus.ICACHE_ren), 32'd0);
    chk("rst_pc_en",   101, 32'(pc_en),          32'd0);
    chk("rst_valid",   101, 32'(bus.inst_valid), 32'd0);
    chk("rst_inst",    101, bus.inst,            32'd0);
    chk("rst_inst_pc", 101, bus.inst_pc,         32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; pc = 32'hA00; bus.ICACHE_stall = 1'b0;
    @(negedge clk);
    chk("restart_ren",   102, 32'(bus.ICACHE_ren),  32'd1);
    chk("restart_addr",  102, 32'(bus.ICACHE_addr), 32'h280);
    chk("restart_pc_en", 102, 32'(pc_en),           32'd1);
    chk("restart_valid", 102, 32'(bus.inst_valid),  32'd0);
    @(posedge clk);
    #1;
    bus.ICACHE_stall = 1'b1;
    @(negedge clk);
    chk("restart_inst",    103, bus.inst,    32'h77);
    chk("restart_inst_pc", 103, bus.inst_pc, 32'hA00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
